// File: rtl/ofdm_tx_pkg.sv
// Shared constants and bin classification for the 256-FFT OFDM transmit chain.
// The bin map (DC, guard band, pilots A/B, data) lives here so every block agrees on it.
package ofdm_tx_pkg;

  localparam int NFFT   = 256;
  localparam int N_DATA = 192;

  localparam logic [7:0] GUARD_LO = 8'd101;
  localparam logic [7:0] GUARD_HI = 8'd155;

  // Group A follows 1-2*w_k, group B follows 1-2*(~w_k)
  localparam logic [3:0][7:0] PILOT_A = {8'd218, 8'd168, 8'd88, 8'd63};
  localparam logic [3:0][7:0] PILOT_B = {8'd243, 8'd193, 8'd38, 8'd13};

  localparam logic signed [15:0] Q_ONE  = 16'sh2000;
  localparam logic signed [15:0] Q_ZERO = 16'sh0000;

  typedef enum logic [1:0] {NULL, PILOT, DATA} bin_kind_t;
  typedef enum logic {IDLE, RUN} tx_state_t;

  function automatic logic is_group_a(input logic [7:0] bin);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) hit |= (bin == PILOT_A[i]);
    return hit;
  endfunction

  function automatic bin_kind_t bin_kind(input logic [7:0] bin);
    bin_kind_t kind;
    kind = DATA;
    if (bin == 8'd0 || (bin >= GUARD_LO && bin <= GUARD_HI)) kind = NULL;
    for (int i = 0; i < 4; i++)
      if (bin == PILOT_A[i] || bin == PILOT_B[i]) kind = PILOT;
    return kind;
  endfunction

endpackage

// File: rtl/pilot_insert_tx_wk_prbs.sv
// Pilot polarity generator x^11+x^9+1; w_k = s[10]^s[8], shifted into the LSB on advance.
// Only compiled when PILOT_PRBS_EN is defined, since only that build instantiates it.
`ifdef PILOT_PRBS_EN
module wk_prbs #(
  parameter logic [10:0] SEED = 11'h7FF
) (
  input  logic clk,
  input  logic rst,
  input  logic seed_load,
  input  logic advance,
  output logic wk
);

  logic [10:0] s;

  assign wk = s[10] ^ s[8];

  always_ff @(posedge clk) begin
    if (rst || seed_load) s <= SEED;
    else if (advance)     s <= {s[9:0], wk};
  end

endmodule
`endif

// File: rtl/pilot_insert_tx.sv
// Subcarrier mapper: 192 data words -> 256 IFFT bins with DC/guard nulls and 8 BPSK pilots.
// PILOT_PRBS_EN selects PRBS pilot polarity; without it all pilots are +PILOT_AMP.
module pilot_insert_tx
  import ofdm_tx_pkg::*;
#(
  parameter int                    DW        = 16,
  parameter logic signed [DW-1:0]  PILOT_AMP = 16'sh2000
`ifdef PILOT_PRBS_EN
  , parameter logic [10:0]         LFSR_SEED = 11'h7FF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [DW-1:0] din_re,
  input  logic [DW-1:0] din_im,
  input  logic          din_val,
  output logic          din_rdy,
  output logic [DW-1:0] dout_re,
  output logic [DW-1:0] dout_im,
  output logic          dout_val,
  input  logic          dout_rdy,
  output logic          dout_last,
  output logic          underrun
);

  tx_state_t     state, state_nxt;
  logic [7:0]    bin_cnt;
  bin_kind_t     kind;
  logic          slot_free, last_hs, load, pilot_neg;
  logic [DW-1:0] pilot_val, smp_re, smp_im;

  assign kind      = bin_kind(bin_cnt);
  assign slot_free = ~dout_val | dout_rdy;
  assign last_hs   = dout_val & dout_rdy & dout_last;

`ifdef PILOT_PRBS_EN
  logic wk;

  wk_prbs #(.SEED(LFSR_SEED)) u_prbs (
    .clk       (clk),
    .rst       (rst),
    .seed_load (frame_start),
    .advance   (last_hs),
    .wk        (wk)
  );

  assign pilot_neg = is_group_a(bin_cnt) ? wk : ~wk;
`else
  assign pilot_neg = 1'b0;
`endif

  assign pilot_val = pilot_neg ? -PILOT_AMP : PILOT_AMP;

  always_ff @(posedge clk) begin
    if (rst || frame_start) state <= IDLE;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (din_val) state_nxt = RUN;
      RUN:     if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bin 0 of the next symbol must wait until bin 255 has been taken downstream
  always_comb begin
    load    = 1'b0;
    din_rdy = 1'b0;
    if (state == RUN) begin
      load    = slot_free & ~(dout_val & dout_last) & ((kind != DATA) | din_val);
      din_rdy = slot_free & (kind == DATA);
    end
  end

  always_comb begin
    smp_re = '0;
    smp_im = '0;
    case (kind)
      PILOT:   smp_re = pilot_val;
      DATA:    begin smp_re = din_re; smp_im = din_im; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      dout_val  <= 1'b0;
      dout_re   <= '0;
      dout_im   <= '0;
      dout_last <= 1'b0;
      bin_cnt   <= '0;
      underrun  <= 1'b0;
    end else begin
      if (load) begin
        dout_val  <= 1'b1;
        dout_re   <= smp_re;
        dout_im   <= smp_im;
        dout_last <= (bin_cnt == 8'hFF);
        bin_cnt   <= bin_cnt + 8'd1;
      end else if (dout_rdy) begin
        dout_val  <= 1'b0;
        dout_last <= 1'b0;
      end
      if (state == RUN && kind == DATA && slot_free && !din_val) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pilot_insert_tx.sv
// Bench for pilot_insert_tx: spot-bin table plus streamed symbols checked against a bin-map model.
// Pilot expectations follow PILOT_PRBS_EN the same way the design does.
module tb_pilot_insert_tx;

  typedef struct { logic [15:0] re; logic [15:0] im; logic last; } bin_t;
  typedef struct { string name; int bin; logic [15:0] re; logic [15:0] im; logic last; } vec_t;

  localparam logic [15:0] AMP  = 16'h2000;
  localparam logic [15:0] NAMP = 16'hE000;
`ifdef PILOT_PRBS_EN
  localparam bit PRBS = 1'b1;
`else
  localparam bit PRBS = 1'b0;
`endif
  localparam logic [15:0] PB0 = PRBS ? NAMP : AMP;  // group B pilot with w_k=0

  logic        clk = 1'b0;
  logic        rst, frame_start, din_val, din_rdy, dout_val, dout_rdy, dout_last, underrun;
  logic [15:0] din_re, din_im, dout_re, dout_im;

  always #5 clk = ~clk;

  pilot_insert_tx dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .din_re(din_re), .din_im(din_im), .din_val(din_val), .din_rdy(din_rdy),
    .dout_re(dout_re), .dout_im(dout_im), .dout_val(dout_val), .dout_rdy(dout_rdy),
    .dout_last(dout_last), .underrun(underrun)
  );

  int   checks = 0, failures = 0, cyc = 0;
  bin_t src_q[$], exp_q[$], out_q[$];
  int   out_cyc[$];
  int   hold = 0, stall_at = -1, stall_len = 0, consumed = 0, lfsr_m = 'h7FF;
  bit   rdy_rand = 1'b0, prev_stall = 1'b0;
  bin_t prev;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic bit is_pa(input int b);
    return b == 63 || b == 88 || b == 168 || b == 218;
  endfunction
  function automatic bit is_pb(input int b);
    return b == 13 || b == 38 || b == 193 || b == 243;
  endfunction

  // One symbol's worth of input words and the 256 bins they must produce
  task automatic push_symbol(input bit ramp);
    int   w, n;
    bin_t d, e;
    w = ((lfsr_m >> 10) ^ (lfsr_m >> 8)) & 1;
    n = 0;
    for (int b = 0; b < 256; b++) begin
      e.last = (b == 255);
      e.im   = 16'h0;
      if (b == 0 || (b >= 101 && b <= 155)) e.re = 16'h0;
      else if (is_pa(b)) e.re = (PRBS && w == 1) ? NAMP : AMP;
      else if (is_pb(b)) e.re = (PRBS && w == 0) ? NAMP : AMP;
      else begin
        n++;
        d.re   = ramp ? 16'(n)  : 16'($urandom);
        d.im   = ramp ? 16'(-n) : 16'($urandom);
        d.last = 1'b0;
        src_q.push_back(d);
        e.re = d.re;
        e.im = d.im;
      end
      exp_q.push_back(e);
    end
    lfsr_m = ((lfsr_m << 1) | w) & 'h7FF;
  endtask

  // Entered and left at posedge+1
  task automatic cycle();
    dout_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (hold > 0) begin
      din_val = 1'b0;
      hold--;
    end else if (src_q.size() > 0) begin
      din_val = 1'b1;
      din_re  = src_q[0].re;
      din_im  = src_q[0].im;
    end else din_val = 1'b0;
    @(negedge clk);
    if (prev_stall)
      chk("hold_stable", {dout_val, dout_last, dout_re, dout_im}, {1'b1, prev.last, prev.re, prev.im});
    prev_stall = dout_val && !dout_rdy;
    prev = '{dout_re, dout_im, dout_last};
    if (dout_val && dout_rdy) begin
      out_q.push_back('{dout_re, dout_im, dout_last});
      out_cyc.push_back(cyc);
    end
    if (din_val && din_rdy) begin
      src_q.delete(0);
      consumed++;
      if (consumed == stall_at) hold = stall_len;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    lfsr_m = 'h7FF;
  endtask

  task automatic run_out(input int n, input int budget, input string name);
    int t = 0;
    while (out_q.size() < n && t < budget) begin
      cycle();
      t++;
    end
    chk(name, out_q.size(), n);
  endtask

  task automatic cmp_stream(input string name);
    int bad = 0, first = -1;
    chk({name, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] != exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s %0d bad bins, first idx %0d got=%h/%h/%b want=%h/%h/%b", name, bad, first,
               out_q[first].re, out_q[first].im, out_q[first].last,
               exp_q[first].re, exp_q[first].im, exp_q[first].last);
    end
  endtask

  initial begin
    tbl[0]  = '{"dc",        0, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{"first",     1, 16'h0001, 16'hFFFF, 1'b0};
    tbl[2]  = '{"b12",      12, 16'h000C, 16'hFFF4, 1'b0};
    tbl[3]  = '{"pilot13",  13, PB0,      16'h0000, 1'b0};
    tbl[4]  = '{"b14",      14, 16'h000D, 16'hFFF3, 1'b0};
    tbl[5]  = '{"pilot38",  38, PB0,      16'h0000, 1'b0};
    tbl[6]  = '{"pilot63",  63, AMP,      16'h0000, 1'b0};
    tbl[7]  = '{"b100",    100, 16'h0060, 16'hFFA0, 1'b0};
    tbl[8]  = '{"guard101",101, 16'h0000, 16'h0000, 1'b0};
    tbl[9]  = '{"guard155",155, 16'h0000, 16'h0000, 1'b0};
    tbl[10] = '{"b156",    156, 16'h0061, 16'hFF9F, 1'b0};
    tbl[11] = '{"pilot168",168, AMP,      16'h0000, 1'b0};
    tbl[12] = '{"pilot243",243, PB0,      16'h0000, 1'b0};
    tbl[13] = '{"b254",    254, 16'h00BF, 16'hFF41, 1'b0};
    tbl[14] = '{"last255", 255, 16'h00C0, 16'hFF40, 1'b1};

    rst = 1'b1; frame_start = 1'b0; din_val = 1'b0; din_re = '0; din_im = '0; dout_rdy = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    chk("rst_dout_val", dout_val, 0);
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_dout", {dout_re, dout_im, dout_last}, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;

    // Ramp symbol at full rate
    pulse_fs();
    out_q.delete(); out_cyc.delete(); exp_q.delete();
    push_symbol(1'b1);
    run_out(256, 1000, "t1_count");
    if (out_q.size() == 256) begin
      chk("t1_rate", out_cyc[255] - out_cyc[0], 255);
      foreach (tbl[i])
        chk({"t1_", tbl[i].name}, {out_q[tbl[i].bin].re, out_q[tbl[i].bin].im, out_q[tbl[i].bin].last},
            {tbl[i].re, tbl[i].im, tbl[i].last});
    end
    chk("t1_underrun", underrun, 0);
    cmp_stream("t1_stream");

    // 20 random symbols with random backpressure
    pulse_fs();
    out_q.delete(); exp_q.delete();
    rdy_rand = 1'b1;
    repeat (20) push_symbol(1'b0);
    run_out(20 * 256, 40000, "t2_count");
    rdy_rand = 1'b0;
    cmp_stream("t2_stream");
    chk("t2_underrun", underrun, 0);

    // Input gap around pilot bin 13
    pulse_fs();
    out_q.delete(); exp_q.delete();
    consumed = 0; stall_at = 12; stall_len = 5;
    push_symbol(1'b1);
    for (int t = 0; t < 500 && consumed < 12; t++) cycle();
    repeat (4) cycle();
    chk("t4_bins_in_gap", out_q.size(), 14);
    if (out_q.size() >= 14) chk("t4_pilot13", out_q[13].re, PB0);
    chk("t4_underrun_set", underrun, 1);
    stall_at = -1;
    run_out(256, 1000, "t4_count");
    chk("t4_underrun_sticky", underrun, 1);
    cmp_stream("t4_stream");

    // Abort mid-symbol; next symbol restarts the PRBS
    out_q.delete(); exp_q.delete();
    push_symbol(1'b0);
    run_out(120, 1000, "t5_pre");
    src_q.delete(); exp_q.delete();
    pulse_fs();
    chk("t5_dout_val", dout_val, 0);
    chk("t5_din_rdy", din_rdy, 0);
    chk("t5_underrun_clr", underrun, 0);
    out_q.delete();
    push_symbol(1'b1);
    run_out(256, 1000, "t5_count");
    if (out_q.size() == 256) begin
      chk("t5_pilot13", out_q[13].re, PB0);
      chk("t5_pilot63", out_q[63].re, AMP);
    end
    cmp_stream("t5_stream");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
